// File: rtl/traffic_phase_controller.sv
// Multi-phase intersection controller: round-robin green/yellow/all-red with an exclusive pedestrian walk.
// Optional emergency preemption is compiled in with `define TRAFFIC_PREEMPT_EN.
module traffic_phase_controller #(
    parameter int NUM_PHASES   = 4,
    parameter int PH_W         = 2,
    parameter int CNT_W        = 8,
    parameter int TICK_DIV     = 1000,
    parameter int GREEN_TIME   = 10,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2,
    parameter int WALK_TIME    = 15
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic                    preempt,
`endif
    input  logic [NUM_PHASES-1:0]   ped_request,
    output logic [2*NUM_PHASES-1:0] phase_light,
    output logic [NUM_PHASES-1:0]   walk,
    output logic [PH_W-1:0]         active_phase,
    output logic [1:0]              ctrl_state
);

    // Prescaler is widened when TICK_DIV does not fit in CNT_W bits.
    localparam int PRE_W = ($clog2(TICK_DIV) > CNT_W) ? $clog2(TICK_DIV) : CNT_W;

    localparam logic [PRE_W-1:0] TICK_LAST    = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST   = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ALL_RED_LAST = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] WALK_LAST    = CNT_W'(WALK_TIME - 1);
    localparam logic [PH_W-1:0]  PH_LAST      = PH_W'(NUM_PHASES - 1);

    localparam logic [2*NUM_PHASES-1:0] RST_LIGHT = {{(2*NUM_PHASES-2){1'b0}}, 2'b10};

    localparam logic [1:0] S_GREEN   = 2'b00;
    localparam logic [1:0] S_YELLOW  = 2'b01;
    localparam logic [1:0] S_ALL_RED = 2'b10;
    localparam logic [1:0] S_WALK    = 2'b11;

    logic [1:0]              r_state;
    logic [PH_W-1:0]         r_phase;
    logic [2*NUM_PHASES-1:0] r_light;
    logic [NUM_PHASES-1:0]   r_walk;
    logic [NUM_PHASES-1:0]   r_pending;
    logic                    r_served;
    logic [PRE_W-1:0]        r_presc;
    logic [CNT_W-1:0]        r_cnt;

    logic                    w_preempt;
    logic                    w_skip;
    logic                    w_tick;
    logic [CNT_W-1:0]        w_last;
    logic                    w_done;
    logic [1:0]              w_state_nxt;
    logic [PH_W-1:0]         w_phase_nxt;
    logic                    w_enter;
    logic                    w_walk_entry;
    logic [2*NUM_PHASES-1:0] w_light_nxt;

`ifdef TRAFFIC_PREEMPT_EN
    logic r_skip;

    // Once preemption is seen, the next all-red exit goes straight to green.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skip <= 1'b0;
        end else if (r_state == S_ALL_RED && w_enter) begin
            r_skip <= 1'b0;
        end else if (preempt) begin
            r_skip <= 1'b1;
        end
    end

    assign w_preempt = preempt;
    assign w_skip    = r_skip;
`else
    assign w_preempt = 1'b0;
    assign w_skip    = 1'b0;
`endif

    assign w_tick = (r_presc == TICK_LAST);

    always_comb begin
        case (r_state)
            S_GREEN:   w_last = GREEN_LAST;
            S_YELLOW:  w_last = YELLOW_LAST;
            S_ALL_RED: w_last = ALL_RED_LAST;
            default:   w_last = WALK_LAST;
        endcase
    end

    assign w_done = w_tick && (r_cnt == w_last);

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        case (r_state)
            S_GREEN: begin
                if (w_preempt || w_done) w_state_nxt = S_YELLOW;
            end
            S_YELLOW: begin
                if (w_done) w_state_nxt = S_ALL_RED;
            end
            S_ALL_RED: begin
                if (!w_preempt && w_done) begin
                    if (!r_served && (|r_pending) && !w_skip) begin
                        w_state_nxt = S_WALK;
                    end else begin
                        w_state_nxt = S_GREEN;
                        w_phase_nxt = (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);
                    end
                end
            end
            default: begin
                if (w_preempt || w_done) w_state_nxt = S_ALL_RED;
            end
        endcase
    end

    assign w_enter      = (w_state_nxt != r_state);
    assign w_walk_entry = w_enter && (w_state_nxt == S_WALK);

    always_comb begin
        w_light_nxt = '0;
        for (int unsigned p = 0; p < NUM_PHASES; p++) begin
            if (PH_W'(p) == w_phase_nxt) begin
                if (w_state_nxt == S_GREEN)       w_light_nxt[2*p +: 2] = 2'b10;
                else if (w_state_nxt == S_YELLOW) w_light_nxt[2*p +: 2] = 2'b01;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_GREEN;
            r_phase   <= '0;
            r_light   <= RST_LIGHT;
            r_walk    <= '0;
            r_pending <= '0;
            r_served  <= 1'b0;
            r_presc   <= '0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_light <= w_light_nxt;

            // Preemption restarts the time base so forced intervals run whole ticks from the event.
            if ((w_preempt && r_state != S_YELLOW) || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PRE_W'(1);
            end

            if (w_enter || (w_preempt && r_state == S_ALL_RED)) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_walk_entry) begin
                r_walk    <= r_pending;
                r_pending <= ped_request;
            end else begin
                r_pending <= r_pending | ped_request;
                if (w_enter && r_state == S_WALK) r_walk <= '0;
            end

            if (w_enter && r_state == S_YELLOW) begin
                r_served <= 1'b0;
            end else if (w_enter && r_state == S_WALK) begin
                r_served <= 1'b1;
            end
        end
    end

    assign phase_light  = r_light;
    assign walk         = r_walk;
    assign active_phase = r_phase;
    assign ctrl_state   = r_state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
module tb_traffic_phase_controller;

  typedef struct {
    int         at;
    bit         which;
    logic [1:0] st;
    logic [1:0] ph;
    logic [5:0] lt;
    logic [2:0] wk;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] ped = '0;
  logic [2:0] ped1 = '0;
`ifdef TRAFFIC_PREEMPT_EN
  logic       preempt = 1'b0;
`endif

  logic [5:0] lt0, lt1;
  logic [2:0] wk0, wk1;
  logic [1:0] ph0, ph1, st0, st1;

  exp_t sb[$];
  exp_t m_e;
  int   tcyc = 0;
  int   base = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  traffic_phase_controller #(
    .NUM_PHASES(3), .PH_W(2), .CNT_W(8), .TICK_DIV(4),
    .GREEN_TIME(5), .YELLOW_TIME(2), .ALL_RED_TIME(1), .WALK_TIME(3)
  ) dut (
    .clk(clk), .reset(rst),
`ifdef TRAFFIC_PREEMPT_EN
    .preempt(preempt),
`endif
    .ped_request(ped), .phase_light(lt0), .walk(wk0),
    .active_phase(ph0), .ctrl_state(st0)
  );

  traffic_phase_controller #(
    .NUM_PHASES(3), .PH_W(2), .CNT_W(8), .TICK_DIV(1),
    .GREEN_TIME(1), .YELLOW_TIME(1), .ALL_RED_TIME(1), .WALK_TIME(1)
  ) dut_fast (
    .clk(clk), .reset(rst),
`ifdef TRAFFIC_PREEMPT_EN
    .preempt(1'b0),
`endif
    .ped_request(ped1), .phase_light(lt1), .walk(wk1),
    .active_phase(ph1), .ctrl_state(st1)
  );

  function automatic void exp_at(input bit which, input int e, input logic [1:0] st,
                                 input logic [1:0] ph, input logic [5:0] lt,
                                 input logic [2:0] wk, input string tag);
    exp_t x;
    int   i;
    x.at = base + e; x.which = which; x.st = st; x.ph = ph; x.lt = lt; x.wk = wk; x.tag = tag;
    i = sb.size();
    while (i > 0 && sb[i-1].at > x.at) i--;
    sb.insert(i, x);
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= tcyc) begin
      logic [12:0] got;
      m_e = sb.pop_front();
      got = m_e.which ? {st1, ph1, lt1, wk1} : {st0, ph0, lt0, wk0};
      checks++;
      if (m_e.at != tcyc || got !== {m_e.st, m_e.ph, m_e.lt, m_e.wk}) begin
        errors++;
        $display("FAIL %s edge %0d: got st=%b ph=%0d light=%b walk=%b, expected st=%b ph=%0d light=%b walk=%b",
                 m_e.tag, m_e.at - base, got[12:11], got[10:9], got[8:3], got[2:0],
                 m_e.st, m_e.ph, m_e.lt, m_e.wk);
      end
    end
  end

  task automatic restart();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = tcyc;
  endtask

  task automatic to_edge(input int e);
    while (tcyc < base + e) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    restart();
    exp_at(0,  0, 2'b00, 2'd0, 6'b000010, 3'b000, "reset");
    exp_at(0, 19, 2'b00, 2'd0, 6'b000010, 3'b000, "green0_end");
    exp_at(0, 20, 2'b01, 2'd0, 6'b000001, 3'b000, "yellow0");
    exp_at(0, 27, 2'b01, 2'd0, 6'b000001, 3'b000, "yellow0_end");
    exp_at(0, 28, 2'b10, 2'd0, 6'b000000, 3'b000, "allred0");
    exp_at(0, 31, 2'b10, 2'd0, 6'b000000, 3'b000, "allred0_end");
    exp_at(0, 32, 2'b00, 2'd1, 6'b001000, 3'b000, "green1");
    exp_at(0, 52, 2'b01, 2'd1, 6'b000100, 3'b000, "yellow1");
    exp_at(0, 60, 2'b10, 2'd1, 6'b000000, 3'b000, "allred1");
    exp_at(0, 64, 2'b00, 2'd2, 6'b100000, 3'b000, "green2");
    exp_at(0, 84, 2'b01, 2'd2, 6'b010000, 3'b000, "yellow2");
    exp_at(0, 92, 2'b10, 2'd2, 6'b000000, 3'b000, "allred2");
    exp_at(0, 96, 2'b00, 2'd0, 6'b000010, 3'b000, "wrap0");
    for (int unsigned e = 0; e <= 12; e++) begin
      logic [1:0] s;
      logic [1:0] p;
      logic [5:0] l;
      s = 2'((e % 3));
      p = 2'(((e / 3) % 3));
      l = (s == 2'd0) ? 6'b000010 : (s == 2'd1) ? 6'b000001 : 6'b000000;
      l = l << (2 * p);
      exp_at(1, int'(e), s, p, l, 3'b000, "fast");
    end
    to_edge(97);
    checks++;
    if (st0 !== 2'b00 || ph0 !== 2'd0 || lt0 !== 6'b000010) begin
      errors++;
      $display("FAIL wrap_hold: got st=%b ph=%0d light=%b", st0, ph0, lt0);
    end

    restart();
    exp_at(0, 31, 2'b10, 2'd0, 6'b000000, 3'b000, "req_allred");
    exp_at(0, 32, 2'b11, 2'd0, 6'b000000, 3'b010, "walk_entry");
    exp_at(0, 43, 2'b11, 2'd0, 6'b000000, 3'b010, "walk_end");
    exp_at(0, 44, 2'b10, 2'd0, 6'b000000, 3'b000, "walk_exit");
    exp_at(0, 47, 2'b10, 2'd0, 6'b000000, 3'b000, "post_walk_allred");
    exp_at(0, 48, 2'b00, 2'd1, 6'b001000, 3'b000, "green1_after_walk");
    exp_at(0, 68, 2'b01, 2'd1, 6'b000100, 3'b000, "yellow1_after_walk");
    exp_at(0, 80, 2'b11, 2'd1, 6'b000000, 3'b001, "second_walk");
    exp_at(0, 91, 2'b11, 2'd1, 6'b000000, 3'b001, "second_walk_end");
    exp_at(0, 92, 2'b10, 2'd1, 6'b000000, 3'b000, "second_walk_exit");
    exp_at(0, 96, 2'b00, 2'd2, 6'b100000, 3'b000, "green2_after_walk");
    to_edge(5);  ped = 3'b010;
    to_edge(6);  ped = 3'b000;
    to_edge(35);
    checks++;
    if (st0 !== 2'b11 || wk0 !== 3'b010) begin
      errors++;
      $display("FAIL mid_walk: got st=%b walk=%b", st0, wk0);
    end
    ped = 3'b001;
    to_edge(36); ped = 3'b000;
    to_edge(97);

    restart();
    exp_at(0,  0, 2'b00, 2'd0, 6'b000010, 3'b000, "reset2");
    exp_at(0, 21, 2'b01, 2'd0, 6'b000001, 3'b000, "pre_reset_yellow");
    exp_at(0, 22, 2'b00, 2'd0, 6'b000010, 3'b000, "async_reset");
    to_edge(3);  ped = 3'b001;
    to_edge(4);  ped = 3'b000;
    to_edge(22);
    checks++;
    if (st0 !== 2'b01) begin
      errors++;
      $display("FAIL mid_yellow: got st=%b", st0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (lt0 !== 6'b000010) begin
      errors++;
      $display("FAIL async_light: got light=%b", lt0);
    end
    checks++;
    if (st0 !== 2'b00 || wk0 !== 3'b000) begin
      errors++;
      $display("FAIL async_state: got st=%b walk=%b", st0, wk0);
    end
    restart();
    exp_at(0,  0, 2'b00, 2'd0, 6'b000010, 3'b000, "after_reset");
    exp_at(0, 31, 2'b10, 2'd0, 6'b000000, 3'b000, "after_reset_allred");
    exp_at(0, 32, 2'b00, 2'd1, 6'b001000, 3'b000, "pending_discarded");
    to_edge(33);

`ifdef TRAFFIC_PREEMPT_EN
    restart();
    exp_at(0, 10, 2'b00, 2'd0, 6'b000010, 3'b000, "pre_preempt");
    exp_at(0, 11, 2'b01, 2'd0, 6'b000001, 3'b000, "preempt_yellow");
    exp_at(0, 18, 2'b01, 2'd0, 6'b000001, 3'b000, "preempt_yellow_end");
    exp_at(0, 19, 2'b10, 2'd0, 6'b000000, 3'b000, "preempt_allred");
    exp_at(0, 30, 2'b10, 2'd0, 6'b000000, 3'b000, "preempt_hold");
    exp_at(0, 33, 2'b10, 2'd0, 6'b000000, 3'b000, "release_allred");
    exp_at(0, 34, 2'b00, 2'd1, 6'b001000, 3'b000, "release_green1");
    exp_at(0, 54, 2'b01, 2'd1, 6'b000100, 3'b000, "release_yellow1");
    exp_at(0, 66, 2'b11, 2'd1, 6'b000000, 3'b010, "preserved_walk");
    to_edge(5);  ped = 3'b010;
    to_edge(6);  ped = 3'b000;
    to_edge(10); preempt = 1'b1;
    to_edge(30);
    checks++;
    if (st0 !== 2'b10) begin
      errors++;
      $display("FAIL preempt_hold_direct: got st=%b", st0);
    end
    preempt = 1'b0;
    to_edge(67);
`endif

    for (int unsigned i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    while (sb.size() > 0) begin
      m_e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for edge %0d never reached, expected st=%b light=%b",
               m_e.tag, m_e.at - base, m_e.st, m_e.lt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
Parametrised multi-phase intersection controller, next generation of the two-lane traffic controller. Sequences NUM_PHASES vehicle phases round-robin through green, yellow and all-red clearance. All durations are in prescaled time units. Latched per-phase pedestrian requests are served as an exclusive pedestrian walk interval. Sits beside the signal-head drivers; all outputs are registered.

Parameters:
NUM_PHASES, 4, number of vehicle phases (2..8)
PH_W, 2, width of active_phase; must be >= clog2(NUM_PHASES), minimum 1
CNT_W, 8, width of the interval and prescaler counters
TICK_DIV, 1000, clk cycles per time unit (>=1)
GREEN_TIME, 10, green duration in ticks (>=1)
YELLOW_TIME, 3, yellow duration in ticks (>=1)
ALL_RED_TIME, 2, all-red clearance in ticks (>=1)
WALK_TIME, 15, pedestrian walk duration in ticks (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
ped_request  input  NUM_PHASES  level request per phase crossing; sampled every cycle
phase_light  output  2*NUM_PHASES  2 bits per phase, phase p at [2p+1:2p]: 00 red, 01 yellow, 10 green; 11 never driven
walk  output  NUM_PHASES  walk indication per crossing
active_phase  output  PH_W  index of the current or most recent vehicle phase
ctrl_state  output  2  00 GREEN, 01 YELLOW, 10 ALL_RED, 11 WALK

Behaviour:
- Reset is asynchronous, active-high, on clk and reset only. Reset values: state GREEN, active_phase 0, phase_light = 10 for phase 0 and 00 for all others, walk 0, pending 0, prescaler 0, interval counter 0, served flag 0.
- Prescaler: free-running 0..TICK_DIV-1. tick is an internal 1-cycle pulse in the cycle where the prescaler equals TICK_DIV-1. With TICK_DIV=1, tick is high every cycle.
- Interval counter: cleared on every state entry; increments on tick. A state of duration T exits on the tick where counter == T-1, so it lasts exactly T ticks.
- Transitions:
  - GREEN -> YELLOW.
  - YELLOW -> ALL_RED, served=0.
  - ALL_RED -> WALK if served=0 and pending != 0.
  - ALL_RED -> GREEN otherwise; active_phase advances (wraps NUM_PHASES-1 -> 0).
  - WALK -> ALL_RED, served=1.
- Phase lights:
  - GREEN: active phase 10, all others 00.
  - YELLOW: active phase 01, all others 00.
  - ALL_RED and WALK: all phases 00.
- Outputs are registered and update on the same edge that changes state. Only one phase is ever non-red.
- Pedestrian requests:
  - pending |= ped_request every cycle.
  - On WALK entry, walk <= pending and those bits of pending clear.
  - A request asserted in the WALK-entry cycle, or during WALK, stays pending for the next walk.
  - walk clears on the WALK -> ALL_RED edge.
- Simultaneous events: a tick coinciding with a request is handled normally; the request is latched and the transition proceeds.
- Reset mid-interval immediately returns all registers to reset values; pending requests are discarded.

Optional Feature:
TRAFFIC_PREEMPT_EN defined:
- Adds input port preempt (1 bit), for emergency preemption.
- GREEN with preempt high: -> YELLOW on the next clk edge, without waiting for a tick.
- WALK with preempt high: -> ALL_RED on the next edge; walk clears and served is set.
- YELLOW runs its full time.
- ALL_RED holds while preempt is high, with the counter held at 0. After release, it completes ALL_RED_TIME, then goes to the next phase GREEN (WALK skipped).
- Pending requests are preserved throughout.
TRAFFIC_PREEMPT_EN undefined: no preempt port and no preemption logic.

Test Plan:
Common configuration: NUM_PHASES=3, TICK_DIV=4, GREEN=5, YELLOW=2, ALL_RED=1, WALK=3; reset released at edge 0; no requests unless stated.
- Basic cycle:
  - phase_light=6'b000010 until edge 20.
  - 6'b000001 at edge 20.
  - 6'b000000 at edge 28.
  - 6'b001000 with active_phase=1 at edge 32.
  - Phase 2 follows, then phase 0 wraps.
- Single request: 1-cycle pulse ped_request=3'b010 at edge 5 -> at edge 32, ctrl_state=11 and walk=3'b010 for 12 cycles. Then ALL_RED for 4 cycles, then phase 1 green at edge 48.
- Request during walk: ped_request=3'b001 asserted during WALK -> walk stays 3'b010 for the current walk. Bit 0 is served at the next ALL_RED exit after a yellow.
- Async reset: reset pulsed mid-YELLOW -> outputs return to reset values immediately, without a clock edge; phase 0 green restarts.
- TICK_DIV=1, all times=1: each state lasts exactly 1 cycle; phase_light never shows two non-red phases.
- With TRAFFIC_PREEMPT_EN: preempt asserted at edge 10 during GREEN -> yellow at edge 11, all-red at edge 19. ALL_RED held while preempt is high; after release, 4 cycles of all-red, then next phase green.
